// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: gray<->binary conversion and reset constants.
// Functions work on PTR_W bits; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

    localparam int PTR_W = 32;

    localparam logic [PTR_W-1:0] PTR_RST   = '0;
    localparam logic             EMPTY_RST = 1'b1;
    localparam logic             AE_RST    = 1'b1;

    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR from the MSB down; zero upper bits leave narrower pointers intact.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rptr_empty_if.sv
// Read-pointer bundle between the FIFO read side and rptr_empty.
// The level signal exists only when RPTR_LEVEL_EN is defined.
interface rptr_empty_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] cnt_gray_async;
    logic [WIDTH-1:0] cnt_bin;
    logic [WIDTH-1:0] cnt_gray;
    logic             empty;
    logic             almost_empty;
`ifdef RPTR_LEVEL_EN
    logic [WIDTH-1:0] level;
`endif

    modport master (
        output en,
        output cnt_gray_async,
        input  cnt_bin,
        input  cnt_gray,
        input  empty,
        input  almost_empty
`ifdef RPTR_LEVEL_EN
        , input level
`endif
    );

    modport slave (
        input  en,
        input  cnt_gray_async,
        output cnt_bin,
        output cnt_gray,
        output empty,
        output almost_empty
`ifdef RPTR_LEVEL_EN
        , output level
`endif
    );

endinterface

// File: rtl/DFF_.sv
// Generic register primitive: async reset and sync clear to RST_VAL, load on en.
// One cycle from d to q; clear has priority over load.
module DFF_ #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] dat_d;
    logic [WIDTH-1:0] dat_q;

    always_comb begin
        dat_d = dat_q;
        if (clr) begin
            dat_d = RST_VAL;
        end else if (en) begin
            dat_d = d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_q <= RST_VAL;
        end else begin
            dat_q <= dat_d;
        end
    end

    assign q = dat_q;

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a gray-coded bus crossing into clk.
// Two-edge latency; the only logic in the path is the synchronous clear.
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] sync_q;

    always_comb begin
        meta_d = clr ? '0 : d;
        sync_d = clr ? '0 : meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rptr_empty.sv
// Async-FIFO read pointer with registered empty/almost_empty; reads while empty are ignored.
// Write pointer seen 2 edges after it changes, flags on the 3rd; RPTR_LEVEL_EN adds the level output.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int AE_THRESH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    rptr_empty_if.slave  bus
);

    localparam logic [WIDTH-1:0] AE_T  = WIDTH'(AE_THRESH);
    localparam logic [WIDTH-1:0] PTR_R = WIDTH'(PTR_RST);

    logic [WIDTH-1:0] wgray_sync;
    logic [WIDTH-1:0] wbin_sync;
    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] ae_gap;
    logic [WIDTH-1:0] cnt_bin_q;
    logic [WIDTH-1:0] cnt_gray_q;
    logic             rd_inc;
    logic             empty_d;
    logic             empty_q;
    logic             ae_d;
    logic             ae_q;

    sync_2ff #(.WIDTH(WIDTH)) u_wgray_sync (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .d   (bus.cnt_gray_async),
        .q   (wgray_sync)
    );

    // Flags look at the pointer after this edge's read against the synced write side.
    always_comb begin
        rd_inc    = bus.en & ~empty_q;
        bin_next  = cnt_bin_q + WIDTH'(rd_inc);
        gray_next = WIDTH'(bin2gray(PTR_W'(bin_next)));
        wbin_sync = WIDTH'(gray2bin(PTR_W'(wgray_sync)));
        ae_gap    = wbin_sync - bin_next;
        empty_d   = (gray_next == wgray_sync);
        ae_d      = (ae_gap <= AE_T);
    end

    DFF_ #(.WIDTH(WIDTH), .RST_VAL(PTR_R)) u_cnt_bin (
        .clk (clk), .rst (rst), .clr (clr), .en (1'b1), .d (bin_next), .q (cnt_bin_q)
    );

    DFF_ #(.WIDTH(WIDTH), .RST_VAL(PTR_R)) u_cnt_gray (
        .clk (clk), .rst (rst), .clr (clr), .en (1'b1), .d (gray_next), .q (cnt_gray_q)
    );

    DFF_ #(.WIDTH(1), .RST_VAL(EMPTY_RST)) u_empty (
        .clk (clk), .rst (rst), .clr (clr), .en (1'b1), .d (empty_d), .q (empty_q)
    );

    DFF_ #(.WIDTH(1), .RST_VAL(AE_RST)) u_almost_empty (
        .clk (clk), .rst (rst), .clr (clr), .en (1'b1), .d (ae_d), .q (ae_q)
    );

    assign bus.cnt_bin      = cnt_bin_q;
    assign bus.cnt_gray     = cnt_gray_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = ae_q;

`ifdef RPTR_LEVEL_EN
    assign bus.level = wbin_sync - cnt_bin_q;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Directed and randomized bench for rptr_empty (WIDTH=5, AE_THRESH=2) against a count-based model.
module tb_rptr_empty;

    localparam int W    = 5;
    localparam int AE   = 2;
    localparam int MODV = 32;

    logic clk;
    logic rst;
    logic clr;

    rptr_empty_if #(.WIDTH(W)) bus ();

    rptr_empty #(.WIDTH(W), .AE_THRESH(AE)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: entries written (m_wp), entries read (m_rd), the two-stage
    // delayed view of the write count, and the flags, all as plain counts mod 32.
    int m_wp, m_rd, m_s1, m_s2;
    bit m_emp, m_ae;

    function automatic logic [31:0] gray_of(input int v);
        return 32'(v ^ (v >> 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rd  = 0;
        m_s1  = 0;
        m_s2  = 0;
        m_emp = 1'b1;
        m_ae  = 1'b1;
    endtask

    task automatic set_wp(input int v);
        m_wp = v % MODV;
        bus.cnt_gray_async = W'(m_wp ^ (m_wp >> 1));
    endtask

    task automatic tick();
        int rd_n, s1_n, s2_n;
        bit emp_n, ae_n;
        if (rst || clr) begin
            rd_n = 0; s1_n = 0; s2_n = 0; emp_n = 1'b1; ae_n = 1'b1;
        end else begin
            rd_n  = (bus.en && !m_emp) ? (m_rd + 1) % MODV : m_rd;
            emp_n = (rd_n == m_s2);
            ae_n  = (((m_s2 - rd_n + MODV) % MODV) <= AE);
            s2_n  = m_s1;
            s1_n  = m_wp;
        end
        @(posedge clk);
        #1;
        m_rd = rd_n; m_s1 = s1_n; m_s2 = s2_n; m_emp = emp_n; m_ae = ae_n;
    endtask

    task automatic check_all();
        check("cnt_bin",      32'(bus.cnt_bin),      32'(m_rd));
        check("cnt_gray",     32'(bus.cnt_gray),     gray_of(m_rd));
        check("empty",        32'(bus.empty),        32'(m_emp));
        check("almost_empty", 32'(bus.almost_empty), 32'(m_ae));
`ifdef RPTR_LEVEL_EN
        check("level",        32'(bus.level),        32'((m_s2 - m_rd + MODV) % MODV));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int writes;
        int guard;
        bit wrapped;
        logic [W-1:0] prev_g;
        logic [W-1:0] prev_b;

        rst = 1'b1;
        clr = 1'b0;
        bus.en = 1'b0;
        set_wp(0);
        model_reset();

        // Reset held, then released with the write side idle.
        tick();
        check_all();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all();
        end

        // Reads while empty must not move the pointer.
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("underflow_bin",  32'(bus.cnt_bin),  32'd0);
            check("underflow_gray", 32'(bus.cnt_gray), 32'd0);
            check_all();
        end
        bus.en = 1'b0;

        // One write: empty falls exactly on the third edge, then one read empties it.
        set_wp(1);
        tick(); check_all();
        tick(); check("empty_edge2", 32'(bus.empty), 32'd1); check_all();
        tick(); check("empty_edge3", 32'(bus.empty), 32'd0); check_all();
        bus.en = 1'b1;
        tick();
        check("one_read_bin",   32'(bus.cnt_bin),  32'd1);
        check("one_read_gray",  32'(bus.cnt_gray), 32'd1);
        check("one_read_empty", 32'(bus.empty),    32'd1);
        check_all();
        bus.en = 1'b0;

        // Five entries visible, drain three: level 5,4,3,2 with almost_empty at 2.
        set_wp(m_rd + 5);
        for (int i = 0; i < 3; i++) begin
            tick(); check_all();
        end
`ifdef RPTR_LEVEL_EN
        check("level_5", 32'(bus.level), 32'd5);
`endif
        check("ae_at_5", 32'(bus.almost_empty), 32'd0);
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_all();
`ifdef RPTR_LEVEL_EN
            check("level_drain", 32'(bus.level), 32'(4 - i));
`endif
        end
        check("ae_at_2", 32'(bus.almost_empty), 32'd1);
        bus.en = 1'b0;

        // Clear with six entries pending and a read requested.
        set_wp(m_rd + 6);
        for (int i = 0; i < 3; i++) begin
            tick(); check_all();
        end
`ifdef RPTR_LEVEL_EN
        check("level_6", 32'(bus.level), 32'd6);
`endif
        clr = 1'b1;
        bus.en = 1'b1;
        set_wp(0);
        tick();
        check("clr_bin",   32'(bus.cnt_bin), 32'd0);
        check("clr_empty", 32'(bus.empty),   32'd1);
        check_all();
        clr = 1'b0;
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check_all();
        end

        // 40 randomized write/read pairs across the pointer wrap.
        writes  = 0;
        guard   = 0;
        wrapped = 1'b0;
        prev_g  = bus.cnt_gray;
        prev_b  = bus.cnt_bin;
        while ((writes < 40 || m_rd != m_wp) && guard < 600) begin
            if (writes < 40 && ((m_wp - m_rd + MODV) % MODV) < 15 && ($urandom_range(0, 1) == 1)) begin
                set_wp(m_wp + 1);
                writes++;
            end
            bus.en = 1'($urandom_range(0, 1));
            tick();
            check_all();
            if (bus.cnt_gray !== prev_g) begin
                check("gray_1bit", 32'($countones(bus.cnt_gray ^ prev_g)), 32'd1);
            end
            if (prev_b == 5'd31 && bus.cnt_bin == 5'd0) wrapped = 1'b1;
            prev_g = bus.cnt_gray;
            prev_b = bus.cnt_bin;
            guard++;
        end
        check("pairs_in_budget", 32'(guard < 600), 32'd1);
        check("ptr_wrapped",     32'(wrapped),     32'd1);
        bus.en = 1'b0;
        tick(); check_all();

        // Reset asserted in the middle of a read cycle.
        set_wp(m_wp + 5);
        for (int i = 0; i < 3; i++) begin
            tick(); check_all();
        end
        bus.en = 1'b1;
        tick(); check_all();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_bin",   32'(bus.cnt_bin),      32'd0);
        check("rst_async_empty", 32'(bus.empty),        32'd1);
        check("rst_async_ae",    32'(bus.almost_empty), 32'd1);
        check_all();
        tick(); check_all();
        rst = 1'b0;
        #2;
        check_all();
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); check_all();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rptr_empty.md
RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning pointer width (address bits + 1 wrap bit); FIFO depth = 2^(WIDTH-1).
REQ-002 SHALL have parameter AE_THRESH, default 2, meaning the almost_empty threshold in entries.
REQ-003 SHALL have port clk, input, 1, read-domain clock (single clock).
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clr, input, 1, synchronous clear.
REQ-006 SHALL have port en, input, 1, read request.
REQ-007 SHALL have port cnt_gray_async, input, WIDTH, write-side gray pointer driven from the write clock domain.
REQ-008 SHALL have port cnt_bin, output, WIDTH, binary read pointer; the low WIDTH-1 bits are the RAM read address.
REQ-009 SHALL have port cnt_gray, output, WIDTH, registered gray read pointer sent to the write domain.
REQ-010 SHALL have port empty, output, 1, registered empty flag.
REQ-011 SHALL have port almost_empty, output, 1, registered flag asserted when level <= AE_THRESH.
REQ-012 SHALL have port level, output, WIDTH, occupied-entry count (present only per REQ-028).

Function
REQ-013 SHALL pass cnt_gray_async through two flops clocked by clk (wgray_sync); no logic is allowed between the flops.
REQ-014 SHALL form bin_next = cnt_bin + (en & ~empty), modulo 2^WIDTH; a read while empty SHALL NOT move the pointer (no underflow).
REQ-015 SHALL form gray_next = bin_next ^ (bin_next >> 1).
REQ-016 SHALL load cnt_bin <= bin_next and cnt_gray <= gray_next on every clk edge.
REQ-017 SHALL register empty <= (gray_next == wgray_sync) on every edge, independent of en.
REQ-018 SHALL convert wgray_sync to binary (wbin_sync) by the prefix-XOR from the MSB.
REQ-019 SHALL register almost_empty <= ((wbin_sync - bin_next) mod 2^WIDTH) <= AE_THRESH.
REQ-020 SHALL give latency: a cnt_gray_async change is visible in wgray_sync after 2 edges, and empty/almost_empty update on the 3rd edge.
REQ-021 SHALL wrap the pointer from 2^WIDTH-1 to 0 with a single gray-bit change and no glitch on empty.
REQ-022 On a simultaneous read of the last entry and a write pointer update, SHALL let empty follow REQ-017 using the current wgray_sync; the new entry appears on a later edge.
REQ-023 SHALL never deassert empty combinationally; only via the register.

Reset
REQ-024 On rst (asynchronous), SHALL set cnt_bin=0, cnt_gray=0, sync flops=0, empty=1, almost_empty=1, level=0.
REQ-025 On clr at an edge, SHALL load the same values synchronously, overriding en.
REQ-026 On reset asserted mid-transfer, SHALL discard in-flight reads; no output SHALL change after rst deasserts until the next edge.

Configuration
REQ-027 SHALL use macro RPTR_LEVEL_EN to control the level output.
REQ-028 With RPTR_LEVEL_EN defined, SHALL drive level = (wbin_sync - cnt_bin) mod 2^WIDTH, combinational from registers.
REQ-029 Without RPTR_LEVEL_EN, SHALL omit the level port, and the subtractor SHALL be kept only for almost_empty; all other behaviour SHALL be identical.

Structure
REQ-030 SHALL place the gray<->binary conversion functions and the reset constants in shared package fifo_pkg.
REQ-031 SHALL instantiate one sub-module, sync_2ff (WIDTH-parameterised two-flop synchronizer, async reset), for REQ-013.
REQ-032 SHALL build all other registers from the existing DFF_ primitive (clk, rst, clr, en, d, q).

Verification (WIDTH=5, AE_THRESH=2)
REQ-033 SHALL cover: reset released, cnt_gray_async=0 -> empty=1, almost_empty=1, cnt_bin=0, level=0 held.
REQ-034 SHALL cover: cnt_gray_async 0->1 (one write) -> empty falls on the 3rd edge; en=1 one cycle -> cnt_bin=1, cnt_gray=1, empty=1 the next edge.
REQ-035 SHALL cover: en=1 held for 4 cycles while empty -> cnt_bin stays 0, cnt_gray stays 0.
REQ-036 SHALL cover: write pointer gray of 5 synced, read 3 -> level 5,4,3,2; almost_empty asserts when level reaches 2.
REQ-037 SHALL cover: 40 write/read pairs -> cnt_bin wraps 31->0, cnt_gray changes exactly 1 bit per increment, and empty never falsely deasserts.
REQ-038 SHALL cover: clr pulse with level=6 and en=1 -> next edge cnt_bin=0, empty=1; rst mid-read -> all outputs at reset values immediately.
